// File: rtl/arp_rx_parser.sv
// arp_rx_parser: ARP receive parser on the 8-bit PHY stream; pulses with opcode/SHA/SPA per accepted frame.
// Define ARP_RX_FCS_CHECK_EN to also require a valid Ethernet FCS and minimum frame length.
module arp_rx_parser #(
    parameter logic [47:0] HOST_MAC  = 48'h0023543C471B,
    parameter logic [31:0] HOST_IP   = 32'h0A000021,
    parameter logic [47:0] BCAST_MAC = 48'hFFFFFFFFFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  i_phy_data,
    input  logic        i_phy_rx_dv,
    output logic        o_arp_valid,
    output logic [1:0]  o_arp_oper,
    output logic [47:0] o_arp_sha,
    output logic [31:0] o_arp_spa,
    output logic        o_busy
);
    typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, ARP_BODY, WAIT_END, DROP} state_t;
    // Fixed bytes n12..n20: ethertype, htype, ptype, hlen, plen, oper high byte
    localparam logic [71:0] FIXED = 72'h080600010800060400;
    state_t      state_q, state_d;
    logic [5:0]  n_q, n_d, n_inc;
    logic        host_q, host_d, bc_q, bc_d, bad, accept;
    logic [1:0]  oper_sh_q, oper_sh_d, oper_q, oper_d;
    logic [47:0] sha_sh_q, sha_sh_d, sha_q, sha_d;
    logic [31:0] spa_sh_q, spa_sh_d, spa_q, spa_d;
    logic        valid_q, valid_d;
    logic [2:0]  mac_k;
    logic [3:0]  fix_k;
    logic [1:0]  ip_k;
    assign mac_k = 3'd5 - n_q[2:0];
    assign fix_k = 4'd4 - n_q[3:0];
    assign ip_k  = 2'd1 - n_q[1:0];
    assign n_inc = n_q == 6'd63 ? n_q : n_q + 6'd1;
`ifdef ARP_RX_FCS_CHECK_EN
    logic [31:0] crc_q, crc_d, crc_rev;
    function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction
    always_comb begin
        crc_d = state_q == PREAMBLE ? 32'hFFFFFFFF :
                (i_phy_rx_dv && (state_q == HEADER || state_q == ARP_BODY || state_q == WAIT_END)) ?
                crc8(crc_q, i_phy_data) : crc_q;
    end
    // Residue is given MSB-first; the shift register holds it bit-reflected
    assign crc_rev = {<<{crc_q}};
    assign accept  = crc_rev == 32'hC704DD7B && n_q >= 6'd46;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) crc_q <= 32'hFFFFFFFF;
        else        crc_q <= crc_d;
`else
    assign accept = 1'b1;
`endif
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        host_d    = host_q;
        bc_d      = bc_q;
        oper_sh_d = oper_sh_q;
        sha_sh_d  = sha_sh_q;
        spa_sh_d  = spa_sh_q;
        valid_d   = 1'b0;
        oper_d    = oper_q;
        sha_d     = sha_q;
        spa_d     = spa_q;
        if (state_q == HEADER && n_q < 6'd6) begin
            host_d = (n_q == 6'd0 || host_q) && i_phy_data == HOST_MAC[{mac_k, 3'b0} +: 8];
            bc_d   = (n_q == 6'd0 || bc_q) && i_phy_data == BCAST_MAC[{mac_k, 3'b0} +: 8];
        end
        bad = (state_q == HEADER && n_q < 6'd6 && !host_d && !bc_d) ||
              (n_q >= 6'd12 && n_q <= 6'd20 && i_phy_data != FIXED[{fix_k, 3'b0} +: 8]) ||
              (n_q == 6'd21 && i_phy_data != 8'h01 && i_phy_data != 8'h02) ||
              (n_q >= 6'd38 && n_q <= 6'd41 && i_phy_data != HOST_IP[{ip_k, 3'b0} +: 8]);
        if (state_q == ARP_BODY && i_phy_rx_dv) begin
            oper_sh_d = n_q == 6'd21 ? i_phy_data[1:0] : oper_sh_q;
            sha_sh_d  = (n_q >= 6'd22 && n_q <= 6'd27) ? {sha_sh_q[39:0], i_phy_data} : sha_sh_q;
            spa_sh_d  = (n_q >= 6'd28 && n_q <= 6'd31) ? {spa_sh_q[23:0], i_phy_data} : spa_sh_q;
        end
        case (state_q)
            IDLE:     if (i_phy_rx_dv) state_d = i_phy_data == 8'h55 ? PREAMBLE : DROP;
            PREAMBLE: begin
                state_d = !i_phy_rx_dv ? IDLE : i_phy_data == 8'h55 ? PREAMBLE :
                          i_phy_data == 8'hD5 ? HEADER : DROP;
                n_d     = 6'd0;
            end
            HEADER, ARP_BODY: begin
                state_d = !i_phy_rx_dv ? IDLE : bad ? DROP : n_q == 6'd13 ? ARP_BODY :
                          n_q == 6'd41 ? WAIT_END : state_q;
                n_d     = n_inc;
            end
            WAIT_END: begin
                if (!i_phy_rx_dv) begin
                    state_d = IDLE;
                    valid_d = accept;
                    oper_d  = accept ? oper_sh_q : oper_q;
                    sha_d   = accept ? sha_sh_q : sha_q;
                    spa_d   = accept ? spa_sh_q : spa_q;
                end else n_d = n_inc;
            end
            DROP:     if (!i_phy_rx_dv) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            n_q       <= 6'd0;
            host_q    <= 1'b0;
            bc_q      <= 1'b0;
            oper_sh_q <= 2'd0;
            sha_sh_q  <= 48'd0;
            spa_sh_q  <= 32'd0;
            valid_q   <= 1'b0;
            oper_q    <= 2'd0;
            sha_q     <= 48'd0;
            spa_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            host_q    <= host_d;
            bc_q      <= bc_d;
            oper_sh_q <= oper_sh_d;
            sha_sh_q  <= sha_sh_d;
            spa_sh_q  <= spa_sh_d;
            valid_q   <= valid_d;
            oper_q    <= oper_d;
            sha_q     <= sha_d;
            spa_q     <= spa_d;
        end
    end
    assign o_arp_valid = valid_q;
    assign o_arp_oper  = oper_q;
    assign o_arp_sha   = sha_q;
    assign o_arp_spa   = spa_q;
    assign o_busy      = state_q != IDLE;
endmodule

// File: tb/tb_arp_rx_parser.sv
// tb_arp_rx_parser: directed table of ARP frames plus truncation, reset and back-to-back sequences.
module tb_arp_rx_parser;
    localparam logic [47:0] HOST = 48'h0023543C471B;
    localparam logic [47:0] BC   = 48'hFFFFFFFFFFFF;
    localparam logic [47:0] SRC  = 48'h020000000001;
    localparam logic [31:0] IP   = 32'h0A000021;
    typedef struct {
        logic [47:0] dst;
        logic [15:0] et;
        logic [7:0]  op;
        logic [47:0] sha;
        logic [31:0] spa;
        logic [31:0] tpa;
        bit          flip;
        int          gap;
        bit          ev;
        logic [1:0]  eo;
        logic [47:0] es;
        logic [31:0] ep;
    } vec_t;
    logic        clk = 1'b0, rst_n = 1'b0, dv = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        valid, busy;
    logic [1:0]  oper;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [31:0] crc;
    logic [7:0]  frm[$], fa[$];
    int          errors = 0, checks = 0, pulses = 0, exp_pulses = 0;
    vec_t        tbl[8];
    arp_rx_parser dut (
        .clk(clk), .rst_n(rst_n), .i_phy_data(data), .i_phy_rx_dv(dv),
        .o_arp_valid(valid), .o_arp_oper(oper), .o_arp_sha(sha), .o_arp_spa(spa), .o_busy(busy)
    );
    always #5 clk = ~clk;
    always @(negedge clk) if (valid === 1'b1) pulses++;
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic push(input logic [7:0] b);
        frm.push_back(b);
        crc = crc ^ {24'd0, b};
        for (int i = 0; i < 8; i++) crc = crc[0] ? (crc >> 1) ^ 32'hEDB88320 : crc >> 1;
    endtask
    task automatic build(input logic [47:0] dst, input logic [15:0] et, input logic [7:0] op,
                         input logic [47:0] s_ha, input logic [31:0] s_pa, input logic [31:0] tpa,
                         input bit flip);
        logic [31:0] fcs;
        frm.delete();
        repeat (7) frm.push_back(8'h55);
        frm.push_back(8'hD5);
        crc = 32'hFFFFFFFF;
        for (int i = 5; i >= 0; i--) push(dst[8*i +: 8]);
        for (int i = 5; i >= 0; i--) push(SRC[8*i +: 8]);
        push(et[15:8]); push(et[7:0]);
        push(8'h00); push(8'h01); push(8'h08); push(8'h00); push(8'h06); push(8'h04);
        push(8'h00); push(op);
        for (int i = 5; i >= 0; i--) push(s_ha[8*i +: 8]);
        for (int i = 3; i >= 0; i--) push(s_pa[8*i +: 8]);
        repeat (6) push(8'h00);
        for (int i = 3; i >= 0; i--) push(tpa[8*i +: 8]);
        repeat (18) push(8'h00);
        fcs = ~crc ^ {31'd0, flip};
        for (int i = 0; i < 4; i++) frm.push_back(fcs[8*i +: 8]);
    endtask
    task automatic send(input int from, input int cnt);
        for (int i = from; i < from + cnt; i++) begin
            data = frm[i];
            dv   = 1'b1;
            @(negedge clk);
        end
    endtask
    task automatic end_frame(input bit ev, input logic [1:0] eo, input logic [47:0] es,
                             input logic [31:0] ep, input string nm);
        chk({nm, " busy_pre"}, busy, 1);
        dv   = 1'b0;
        data = 8'h00;
        @(negedge clk);
        chk({nm, " valid"}, valid, ev);
        chk({nm, " busy"}, busy, 0);
        chk({nm, " oper"}, oper, eo);
        chk({nm, " sha"}, sha, es);
        chk({nm, " spa"}, spa, ep);
        exp_pulses += ev ? 1 : 0;
        @(negedge clk);
        chk({nm, " valid_end"}, valid, 0);
        chk({nm, " pulses"}, pulses, exp_pulses);
    endtask
    initial begin
        tbl[0] = '{BC, 16'h0806, 8'h01, 48'h001122334455, 32'h0A000002, IP, 1'b0, 2,
                   1'b1, 2'd1, 48'h001122334455, 32'h0A000002};
        tbl[1] = '{HOST, 16'h0806, 8'h02, 48'h66778899AABB, 32'h0A000002, IP, 1'b0, 100,
                   1'b1, 2'd2, 48'h66778899AABB, 32'h0A000002};
        tbl[2] = '{BC, 16'h0806, 8'h01, 48'h001122334455, 32'h0A000003, 32'h0A000022, 1'b0, 2,
                   1'b0, 2'd2, 48'h66778899AABB, 32'h0A000002};
        tbl[3] = '{BC, 16'h0800, 8'h01, 48'h001122334455, 32'h0A000003, IP, 1'b0, 2,
                   1'b0, 2'd2, 48'h66778899AABB, 32'h0A000002};
        tbl[4] = '{BC, 16'h0806, 8'h03, 48'h001122334455, 32'h0A000003, IP, 1'b0, 2,
                   1'b0, 2'd2, 48'h66778899AABB, 32'h0A000002};
        tbl[5] = '{48'h0023543C471C, 16'h0806, 8'h01, 48'h001122334455, 32'h0A000003, IP, 1'b0, 2,
                   1'b0, 2'd2, 48'h66778899AABB, 32'h0A000002};
`ifdef ARP_RX_FCS_CHECK_EN
        tbl[6] = '{BC, 16'h0806, 8'h01, 48'hAABBCCDDEEFF, 32'h0A000005, IP, 1'b1, 2,
                   1'b0, 2'd2, 48'h66778899AABB, 32'h0A000002};
`else
        tbl[6] = '{BC, 16'h0806, 8'h01, 48'hAABBCCDDEEFF, 32'h0A000005, IP, 1'b1, 2,
                   1'b1, 2'd1, 48'hAABBCCDDEEFF, 32'h0A000005};
`endif
        tbl[7] = '{BC, 16'h0806, 8'h01, 48'h001122334455, 32'h0A000007, IP, 1'b0, 2,
                   1'b1, 2'd1, 48'h001122334455, 32'h0A000007};
        repeat (3) @(negedge clk);
        chk("rst valid", valid, 0);
        chk("rst busy", busy, 0);
        chk("rst oper", oper, 0);
        chk("rst sha", sha, 0);
        chk("rst spa", spa, 0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            build(tbl[k].dst, tbl[k].et, tbl[k].op, tbl[k].sha, tbl[k].spa, tbl[k].tpa, tbl[k].flip);
            send(0, frm.size());
            end_frame(tbl[k].ev, tbl[k].eo, tbl[k].es, tbl[k].ep, $sformatf("v%0d", k));
            repeat (tbl[k].gap) @(negedge clk);
            if (tbl[k].gap > 50) begin
                chk("hold oper", oper, tbl[k].eo);
                chk("hold sha", sha, tbl[k].es);
                chk("hold spa", spa, tbl[k].ep);
                chk("hold pulses", pulses, exp_pulses);
            end
        end
        // Truncated: dv drops where byte n30 would be
        build(BC, 16'h0806, 8'h01, 48'h001122334455, 32'h0A000008, IP, 1'b0);
        send(0, 8 + 30);
        end_frame(1'b0, 2'd1, 48'h001122334455, 32'h0A000007, "trunc");
        // Reset asserted while byte n20 is on the bus, released on n21
        build(BC, 16'h0806, 8'h01, 48'h001122334455, 32'h0A000008, IP, 1'b0);
        send(0, 8 + 20);
        data  = frm[28];
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst busy", busy, 0);
        chk("midrst valid", valid, 0);
        chk("midrst oper", oper, 0);
        chk("midrst sha", sha, 0);
        chk("midrst spa", spa, 0);
        rst_n = 1'b1;
        data  = frm[29];
        @(negedge clk);
        chk("postrst drop busy", busy, 1);
        send(30, frm.size() - 30);
        end_frame(1'b0, 2'd0, 48'd0, 32'd0, "postrst");
        build(BC, 16'h0806, 8'h01, 48'h001122334455, 32'h0A000009, IP, 1'b0);
        send(0, frm.size());
        end_frame(1'b1, 2'd1, 48'h001122334455, 32'h0A000009, "recover");
        // Back-to-back with a single idle cycle between frames
        build(BC, 16'h0806, 8'h01, 48'h001122334455, 32'h0A000011, IP, 1'b0);
        fa = frm;
        build(BC, 16'h0806, 8'h01, 48'h001122334455, 32'h0A000012, IP, 1'b0);
        for (int i = 0; i < fa.size(); i++) begin
            data = fa[i];
            dv   = 1'b1;
            @(negedge clk);
        end
        dv   = 1'b0;
        data = 8'h00;
        @(negedge clk);
        chk("b2b first valid", valid, 1);
        chk("b2b first spa", spa, 32'h0A000011);
        chk("b2b first busy", busy, 0);
        exp_pulses++;
        send(0, frm.size());
        end_frame(1'b1, 2'd1, 48'h001122334455, 32'h0A000012, "b2b second");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/arp_rx_parser.md
Name: arp_rx_parser

Overview:
- Receive-side ARP frame parser on the 8-bit PHY receive stream; the counterpart of the ARP transmit path in the Ethernet top level.
- Strips preamble/SFD, checks Ethernet and ARP headers on the fly, and captures sender MAC/IP and opcode.
- Emits a one-cycle result pulse at end of frame for the top-level state machine: ARP request received -> send response; ARP reply received -> target resolved.

Parameters:
- HOST_MAC, 48'h0023543C471B, own MAC; accepted as destination MAC.
- HOST_IP, 32'h0A000021, own IP; ARP TPA must equal this.
- BCAST_MAC, 48'hFFFFFFFFFFFF, broadcast destination MAC, also accepted.

Ports:
- clk  in  1  system clock; PHY rx data sampled on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_phy_data  in  8  receive byte.
- i_phy_rx_dv  in  1  receive data valid.
- o_arp_valid  out  1  one-cycle pulse: accepted ARP frame.
- o_arp_oper  out  2  1 = request, 2 = reply; held until next pulse.
- o_arp_sha  out  48  sender hardware address; held.
- o_arp_spa  out  32  sender protocol address; held.
- o_busy  out  1  high while state is not IDLE.

Behaviour:
- Reset: state IDLE, byte counter 0, all outputs 0.
- Byte index n counts from 0 at the first byte after SFD; the counter saturates at 63 and does not wrap.
- States and transitions:
  - IDLE: dv=1 with byte 0x55 -> PREAMBLE; dv=1 with any other byte -> DROP.
  - PREAMBLE: 0x55 -> stay; 0xD5 -> HEADER with n=0; other -> DROP.
  - HEADER (n 0..13): n0-5 must equal HOST_MAC or BCAST_MAC, tracked as two running match flags; n6-11 ignored; n12-13 must be 0x08,0x06. At n13 -> ARP_BODY.
  - ARP_BODY (n 14..41): n14-15 = 00 01; n16-17 = 08 00; n18 = 06; n19 = 04; n20 = 00; n21 = 01 or 02 (latched as oper); n22-27 shadow SHA; n28-31 shadow SPA; n32-37 ignored; n38-41 must equal HOST_IP. After n41 -> WAIT_END.
  - WAIT_END: absorbs padding and FCS while dv=1.
  - DROP: waits for dv=0 -> IDLE, with no pulse.
- Any field mismatch -> DROP on the same edge.
- dv=0 in PREAMBLE, HEADER or ARP_BODY (truncated frame) -> IDLE, no pulse.
- dv=0 sampled in WAIT_END -> IDLE. On the next cycle:
  - o_arp_valid=1 for exactly one cycle;
  - o_arp_oper, o_arp_sha and o_arp_spa are loaded from the shadows in the same cycle.
  - Latency is 1 clk from the first dv-low sample.
- Shadow registers never disturb the held outputs until a frame is accepted.
- A new frame starting (dv=1) on the cycle of the pulse is accepted normally; IDLE is already reached.
- rst_n low mid-frame aborts immediately; after release, bytes are ignored until dv=0 is seen. The block starts in IDLE, but DROP is taken if the first byte is not 0x55.

Optional Feature:
- Macro ARP_RX_FCS_CHECK_EN.
- Defined:
  - Reflected CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF) runs over every byte from n=0 through the end of frame, FCS included.
  - The pulse requires residue 0xC704DD7B and at least 46 bytes after SFD; otherwise the frame is silently discarded.
  - Latency is unchanged.
- Not defined: no CRC logic; FCS bytes are absorbed in WAIT_END; a frame ending at n>=41 is accepted.

Test Plan:
- Broadcast ARP request: SHA 00:11:22:33:44:55, SPA 0A.00.00.02, TPA 0A.00.00.21, 18 pad bytes + FCS -> one pulse 1 clk after dv falls; oper=1, sha=48'h001122334455, spa=32'h0A000002.
- Unicast ARP reply to HOST_MAC from SPA 0A.00.00.02 -> pulse, oper=2; outputs held unchanged through a following idle period of 100 clk.
- Same request with TPA 0A.00.00.22, then ethertype 0x0800, then oper=3 -> no pulse, o_busy drops 1 clk after dv falls, outputs keep previous values.
- dv deasserted at n=30, then rst_n pulsed low during a later frame at n=20 -> no pulse either time; a following valid request is accepted.
- Two back-to-back requests with a 1-cycle dv gap, different SPAs -> two pulses, each carrying its own SPA.
- ARP_RX_FCS_CHECK_EN defined: correct FCS -> pulse; one FCS bit flipped -> no pulse; without the macro the flipped-FCS frame still pulses.
